// File: rtl/ts_os_collector_if.sv
// rtl/ts_os_collector_if.sv - PIPE symbol input and ordered-set result bundle for ts_os_collector
interface ts_os_collector_if #(
  parameter int LANES = 16
);
  logic [LANES*8-1:0]   rxData;
  logic [LANES-1:0]     rxDataK;
  logic [LANES-1:0]     rxValid;
  logic [4:0]           numberOfDetectedLanes;
  logic [LANES*128-1:0] orderedSets;
  logic                 validOrderedSets;
  logic [LANES-1:0]     osIsTS2;
  logic [LANES-1:0]     osError;
  logic                 skewError;

  modport master (
    output rxData, rxDataK, rxValid, numberOfDetectedLanes,
    input  orderedSets, validOrderedSets, osIsTS2, osError, skewError
  );

  modport slave (
    input  rxData, rxDataK, rxValid, numberOfDetectedLanes,
    output orderedSets, validOrderedSets, osIsTS2, osError, skewError
  );
endinterface

// File: rtl/ts_os_collector.sv
// rtl/ts_os_collector.sv - per-lane TS1/TS2 hunter with lane-aligned ordered-set emission
module ts_os_collector #(
  parameter int LANES       = 16,
  parameter int SKEW_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  ts_os_collector_if.slave bus
);
  localparam int         AW     = $clog2(SKEW_CYCLES + 1);
  localparam logic [4:0] LANES5 = 5'(LANES);
  localparam logic [7:0] COM = 8'hBC, PAD = 8'hF7, SKP = 8'h1C, IDL = 8'h7C, FTS = 8'h3C;
  localparam logic [7:0] TS1 = 8'h4A, TS2 = 8'h45;

  typedef enum logic {HUNT, COLLECT} lane_st_e;

  lane_st_e             st_q   [LANES];
  lane_st_e             st_d   [LANES];
  logic [3:0]           idx_q  [LANES];
  logic [3:0]           idx_d  [LANES];
  logic                 ts2_q  [LANES];
  logic                 ts2_d  [LANES];
  logic [127:0]         coll_q [LANES];
  logic [127:0]         coll_d [LANES];
  logic [127:0]         buf_q  [LANES];
  logic [127:0]         buf_d  [LANES];
  logic [AW-1:0]        age_q  [LANES];
  logic [AW-1:0]        age_d  [LANES];
  logic [LANES-1:0]     buf_ts2_q, buf_ts2_d;
  logic [LANES-1:0]     pend_q, pend_d;
  logic [4:0]           act_q, act_d;
  logic [LANES*128-1:0] os_q, os_d;
  logic                 valid_q, valid_d;
  logic [LANES-1:0]     os_ts2_q, os_ts2_d;
  logic [LANES-1:0]     os_err_q, os_err_d;
  logic                 skew_err_q, skew_err_d;

  logic [LANES-1:0]     done, err, act_mask, aged;
  logic                 emit, timeout;

  always_comb begin
    logic [7:0] sym;
    logic       k;
    logic       accept;
    act_d    = (bus.numberOfDetectedLanes > LANES5) ? LANES5 : bus.numberOfDetectedLanes;
    done     = '0;
    err      = '0;
    act_mask = '0;
    aged     = '0;
    for (int i = 0; i < LANES; i++) begin
      st_d[i]   = st_q[i];
      idx_d[i]  = idx_q[i];
      ts2_d[i]  = ts2_q[i];
      coll_d[i] = coll_q[i];
      sym       = bus.rxData[8*i +: 8];
      k         = bus.rxDataK[i];
      accept    = 1'b0;
      act_mask[i] = (i < int'(act_q));
      aged[i]     = (age_q[i] >= AW'(SKEW_CYCLES - 1));
      if (bus.rxValid[i]) begin
        if (k && sym == COM) begin
          st_d[i]         = COLLECT;
          idx_d[i]        = 4'd1;
          coll_d[i][7:0]  = COM;
        end else if (st_q[i] == COLLECT) begin
          if (k) begin
            if ((idx_q[i] == 4'd1 || idx_q[i] == 4'd2) && sym == PAD) begin
              accept = 1'b1;
            end else if (idx_q[i] == 4'd1 && (sym == SKP || sym == IDL || sym == FTS)) begin
              st_d[i] = HUNT;
            end else begin
              st_d[i] = HUNT;
              err[i]  = 1'b1;
            end
          end else if (idx_q[i] < 4'd6) begin
            accept = 1'b1;
          end else if (idx_q[i] == 4'd6 && (sym == TS1 || sym == TS2)) begin
            accept   = 1'b1;
            ts2_d[i] = (sym == TS2);
          end else if (idx_q[i] > 4'd6 && sym == (ts2_q[i] ? TS2 : TS1)) begin
            accept = 1'b1;
          end else begin
            st_d[i] = HUNT;
            err[i]  = 1'b1;
          end
          if (accept) begin
            coll_d[i][8*int'(idx_q[i]) +: 8] = sym;
            if (idx_q[i] == 4'd15) begin
              done[i] = 1'b1;
              st_d[i] = HUNT;
            end else begin
              idx_d[i] = idx_q[i] + 4'd1;
            end
          end
        end
      end
    end

    // Inactive lanes count as satisfied so only active lanes gate emission and timeout.
    emit    = (act_q != 5'd0) && (&(pend_q | ~act_mask));
    timeout = |(pend_q & act_mask & aged);

    pend_d     = (emit || timeout) ? '0 : pend_q;
    pend_d     = pend_d | done;
    buf_ts2_d  = buf_ts2_q;
    os_d       = os_q;
    os_ts2_d   = os_ts2_q;
    valid_d    = emit;
    skew_err_d = timeout && !emit;
    os_err_d   = err;
    for (int i = 0; i < LANES; i++) begin
      buf_d[i] = buf_q[i];
      age_d[i] = age_q[i];
      if (done[i]) begin
        buf_d[i]     = coll_d[i];
        buf_ts2_d[i] = ts2_q[i];
        age_d[i]     = '0;
      end else if (pend_q[i] && age_q[i] < AW'(SKEW_CYCLES)) begin
        age_d[i] = age_q[i] + AW'(1);
      end
      if (emit) begin
        os_d[128*i +: 128] = act_mask[i] ? buf_q[i] : 128'd0;
        os_ts2_d[i]        = act_mask[i] & buf_ts2_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        st_q[i]   <= HUNT;
        idx_q[i]  <= '0;
        ts2_q[i]  <= 1'b0;
        coll_q[i] <= '0;
        buf_q[i]  <= '0;
        age_q[i]  <= '0;
      end
      buf_ts2_q  <= '0;
      pend_q     <= '0;
      act_q      <= '0;
      os_q       <= '0;
      valid_q    <= 1'b0;
      os_ts2_q   <= '0;
      os_err_q   <= '0;
      skew_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        st_q[i]   <= st_d[i];
        idx_q[i]  <= idx_d[i];
        ts2_q[i]  <= ts2_d[i];
        coll_q[i] <= coll_d[i];
        buf_q[i]  <= buf_d[i];
        age_q[i]  <= age_d[i];
      end
      buf_ts2_q  <= buf_ts2_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
      os_q       <= os_d;
      valid_q    <= valid_d;
      os_ts2_q   <= os_ts2_d;
      os_err_q   <= os_err_d;
      skew_err_q <= skew_err_d;
    end
  end

  assign bus.orderedSets      = os_q;
  assign bus.validOrderedSets = valid_q;
  assign bus.osIsTS2          = os_ts2_q;
  assign bus.osError          = os_err_q;
  assign bus.skewError        = skew_err_q;
endmodule

// File: tb/tb_ts_os_collector.sv
// tb/tb_ts_os_collector.sv - directed self-checking bench for ts_os_collector
module tb_ts_os_collector;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   strobe_cnt = 0, strobe_cyc = -1;
  int   skew_cnt = 0, skew_cyc = -1;
  int   err_cnt = 0, err1_cnt = 0;
  int   last_edge = 0;

  ts_os_collector_if #(.LANES(16)) bus ();

  ts_os_collector #(.LANES(16), .SKEW_CYCLES(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.validOrderedSets) begin strobe_cnt++; strobe_cyc = cyc; end
    if (bus.skewError) begin skew_cnt++; skew_cyc = cyc; end
    err_cnt += $countones(bus.osError);
    if (bus.osError[1]) err1_cnt++;
  end

  function automatic logic [7:0] tsym(input int l, input int k, input logic t2);
    case (k)
      0:       return 8'hBC;
      1:       return 8'h01;
      2:       return 8'(l);
      3:       return 8'h20;
      4:       return 8'h02;
      5:       return 8'h00;
      default: return t2 ? 8'h45 : 8'h4A;
    endcase
  endfunction

  function automatic logic [127:0] exp_os(input int l, input logic t2);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = tsym(l, k, t2);
    return v;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.rxValid = '0;
    bus.rxDataK = '0;
    bus.rxData  = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic one_sym(input int l, input logic [7:0] d, input logic k);
    idle_inputs();
    bus.rxValid[l]       = 1'b1;
    bus.rxDataK[l]       = k;
    bus.rxData[8*l +: 8] = d;
    tick(1);
    idle_inputs();
  endtask

  // Sends one TS per enabled lane; late_lane starts `late` cycles after the others.
  task automatic send_ts(input logic [15:0] en, input logic [15:0] t2m, input int late_lane,
                         input int late, input int bad_lane, input int bad_k,
                         input logic [7:0] bad_val, input int stop);
    int ncyc;
    ncyc = (stop > 0) ? stop : 16 + late;
    for (int c = 0; c < ncyc; c++) begin
      for (int l = 0; l < 16; l++) begin
        int k;
        k = c - ((l == late_lane) ? late : 0);
        if (en[l] && k >= 0 && k < 16) begin
          bus.rxValid[l]       = 1'b1;
          bus.rxDataK[l]       = (k == 0);
          bus.rxData[8*l +: 8] = (l == bad_lane && k == bad_k) ? bad_val : tsym(l, k, t2m[l]);
        end else begin
          bus.rxValid[l]       = 1'b0;
          bus.rxDataK[l]       = 1'b0;
          bus.rxData[8*l +: 8] = 8'h00;
        end
      end
      tick(1);
    end
    idle_inputs();
    last_edge = cyc;
  endtask

  initial begin
    int s0, e0, e10, k0;
    reset = 1'b1;
    bus.numberOfDetectedLanes = 5'd0;
    idle_inputs();
    tick(3);
    reset = 1'b0;
    check("rst_os", 128'(|bus.orderedSets), 128'd0);
    check("rst_valid", 128'(bus.validOrderedSets), 128'd0);
    check("rst_ts2", 128'(bus.osIsTS2), 128'd0);
    check("rst_oserr", 128'(bus.osError), 128'd0);
    check("rst_skew", 128'(bus.skewError), 128'd0);

    // 4 active lanes, TS1 everywhere; lanes 4..15 also complete but must read back zero
    bus.numberOfDetectedLanes = 5'd4;
    tick(1);
    s0 = strobe_cnt; e0 = err_cnt;
    send_ts(16'hFFFF, 16'h0000, -1, 0, -1, 0, 8'h00, 0);
    tick(3);
    check("ts1_strobes", 128'(strobe_cnt - s0), 128'd1);
    check("ts1_latency", 128'(strobe_cyc), 128'(last_edge + 1));
    check("ts1_l0_b0", 128'(bus.orderedSets[7:0]), 128'hBC);
    check("ts1_l3_b15", 128'(bus.orderedSets[3*128+120 +: 8]), 128'h4A);
    check("ts1_l2_os", bus.orderedSets[2*128 +: 128], exp_os(2, 1'b0));
    check("ts1_ts2", 128'(bus.osIsTS2), 128'd0);
    check("ts1_hi_zero", 128'(|bus.orderedSets[2047:512]), 128'd0);
    check("ts1_noerr", 128'(err_cnt - e0), 128'd0);

    // TS2 with lane 2 skewed by 5 cycles
    s0 = strobe_cnt;
    send_ts(16'h000F, 16'hFFFF, 2, 5, -1, 0, 8'h00, 0);
    tick(3);
    check("skew5_strobes", 128'(strobe_cnt - s0), 128'd1);
    check("skew5_latency", 128'(strobe_cyc), 128'(last_edge + 1));
    check("skew5_ts2", 128'(bus.osIsTS2), 128'h000F);
    check("skew5_l2_os", bus.orderedSets[2*128 +: 128], exp_os(2, 1'b1));

    // COM then SKP on lane 0 abandons silently
    s0 = strobe_cnt; e0 = err_cnt;
    one_sym(0, 8'hBC, 1'b1);
    one_sym(0, 8'h1C, 1'b1);
    one_sym(0, 8'h1C, 1'b1);
    one_sym(0, 8'h1C, 1'b1);
    send_ts(16'h000F, 16'h0000, -1, 0, -1, 0, 8'h00, 0);
    tick(3);
    check("skp_noerr", 128'(err_cnt - e0), 128'd0);
    check("skp_strobes", 128'(strobe_cnt - s0), 128'd1);
    check("skp_l0_os", bus.orderedSets[127:0], exp_os(0, 1'b0));
    check("skp_ts2", 128'(bus.osIsTS2), 128'd0);

    // TS2 identifier inside a TS1 on lane 1
    s0 = strobe_cnt; e0 = err_cnt; e10 = err1_cnt;
    send_ts(16'h000F, 16'h0000, -1, 0, 1, 10, 8'h45, 0);
    tick(3);
    check("bad_err1", 128'(err1_cnt - e10), 128'd1);
    check("bad_errall", 128'(err_cnt - e0), 128'd1);
    check("bad_nostrobe", 128'(strobe_cnt - s0), 128'd0);
    send_ts(16'h0002, 16'h0000, -1, 0, -1, 0, 8'h00, 0);
    tick(3);
    check("fix_strobes", 128'(strobe_cnt - s0), 128'd1);
    check("fix_l1_os", bus.orderedSets[128 +: 128], exp_os(1, 1'b0));

    // Only lane 0 completes: timeout after SKEW_CYCLES
    s0 = strobe_cnt; k0 = skew_cnt;
    send_ts(16'h0001, 16'h0000, -1, 0, -1, 0, 8'h00, 0);
    tick(40);
    check("to_skew_cnt", 128'(skew_cnt - k0), 128'd1);
    check("to_skew_cyc", 128'(skew_cyc), 128'(last_edge + 32));
    check("to_nostrobe", 128'(strobe_cnt - s0), 128'd0);

    // Reset in the middle of a TS2, then a full TS1
    send_ts(16'h000F, 16'hFFFF, -1, 0, -1, 0, 8'h00, 8);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_rst_os", 128'(|bus.orderedSets), 128'd0);
    check("mid_rst_valid", 128'(bus.validOrderedSets), 128'd0);
    tick(1);
    s0 = strobe_cnt;
    send_ts(16'h000F, 16'h0000, -1, 0, -1, 0, 8'h00, 0);
    tick(3);
    check("post_rst_strobes", 128'(strobe_cnt - s0), 128'd1);
    check("post_rst_l0_os", bus.orderedSets[127:0], exp_os(0, 1'b0));
    check("post_rst_l3_os", bus.orderedSets[3*128 +: 128], exp_os(3, 1'b0));
    check("post_rst_ts2", 128'(bus.osIsTS2), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
